// File: rtl/alu_exec_unit.sv
// Registered EX-stage ALU with Z/C/N flags; latency 1, shifts n cycles, multiply WIDTH cycles.
// Backpressure: busy is high while a shift/multiply iterates; ops presented during busy or flush are dropped.
module alu_exec_unit #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             flush,
    output logic             busy,
    output logic             out_valid,
    output logic [WIDTH-1:0] out,
    output logic [2:0]       flag
);

    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_NOT  = 4'h2;
    localparam logic [3:0] OP_PASA = 4'h3;
    localparam logic [3:0] OP_PASB = 4'h4;
    localparam logic [3:0] OP_SUB  = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_OR   = 4'h7;
    localparam logic [3:0] OP_INC  = 4'h8;
    localparam logic [3:0] OP_DEC  = 4'h9;
    localparam logic [3:0] OP_SETC = 4'hA;
    localparam logic [3:0] OP_CLRC = 4'hB;
    localparam logic [3:0] OP_SHL  = 4'hC;
    localparam logic [3:0] OP_SHR  = 4'hD;
    localparam logic [3:0] OP_MUL  = 4'hE;

    localparam logic [SHW-1:0] N_ONE   = SHW'(1);
    localparam logic [SHW-1:0] CNT_MUL = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        MUL   = 2'd2
    } state_t;

    state_t               state_q;
    logic [SHW-1:0]       cnt_q;
    logic [WIDTH-1:0]     sh_q;
    logic                 shl_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [2*WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]     mplier_q;
    logic [WIDTH-1:0]     out_q;
    logic                 vld_q;
    logic [2:0]           flag_q;

    logic [SHW-1:0]       n;
    logic [WIDTH:0]       sum, diff, inc, dec;
    logic [WIDTH-1:0]     in1_shl1, in1_shr1;
    logic                 accept;

    assign n        = in2[SHW-1:0];
    assign sum      = {1'b0, in1} + {1'b0, in2};
    assign diff     = {1'b0, in1} - {1'b0, in2};
    assign inc      = {1'b0, in1} + {{WIDTH{1'b0}}, 1'b1};
    assign dec      = {1'b0, in1} - {{WIDTH{1'b0}}, 1'b1};
    assign in1_shl1 = {in1[WIDTH-2:0], 1'b0};
    assign in1_shr1 = {1'b0, in1[WIDTH-1:1]};
    assign accept   = in_valid & ~busy & ~flush;

    // Single-cycle result; bit WIDTH of the extended add/sub is the carry/borrow
    logic             sc_vld, sc_c, sc_zn, start_shift, start_mul;
    logic [WIDTH-1:0] sc_res;
    logic [2:0]       sc_flag;

    always_comb begin
        sc_vld      = 1'b0;
        sc_res      = out_q;
        sc_c        = flag_q[1];
        sc_zn       = 1'b1;
        start_shift = 1'b0;
        start_mul   = 1'b0;
        case (alu_op)
            OP_ADD:  begin sc_vld = 1'b1; sc_res = sum[WIDTH-1:0];  sc_c = sum[WIDTH];  end
            OP_NOT:  begin sc_vld = 1'b1; sc_res = ~in2;                                 end
            OP_PASA: begin sc_vld = 1'b1; sc_res = in1;                                  end
            OP_PASB: begin sc_vld = 1'b1; sc_res = in2;                                  end
            OP_SUB:  begin sc_vld = 1'b1; sc_res = diff[WIDTH-1:0]; sc_c = diff[WIDTH]; end
            OP_AND:  begin sc_vld = 1'b1; sc_res = in1 & in2;                            end
            OP_OR:   begin sc_vld = 1'b1; sc_res = in1 | in2;                            end
            OP_INC:  begin sc_vld = 1'b1; sc_res = inc[WIDTH-1:0];  sc_c = inc[WIDTH];  end
            OP_DEC:  begin sc_vld = 1'b1; sc_res = dec[WIDTH-1:0];  sc_c = dec[WIDTH];  end
            OP_SETC: begin sc_vld = 1'b1; sc_c = 1'b1; sc_zn = 1'b0;                     end
            OP_CLRC: begin sc_vld = 1'b1; sc_c = 1'b0; sc_zn = 1'b0;                     end
            OP_SHL, OP_SHR: begin
                if (n > N_ONE) begin
                    start_shift = 1'b1;
                end else begin
                    sc_vld = 1'b1;
                    if (n == N_ONE) begin
                        sc_res = (alu_op == OP_SHL) ? in1_shl1 : in1_shr1;
                        sc_c   = (alu_op == OP_SHL) ? in1[WIDTH-1] : in1[0];
                    end else begin
                        sc_res = in1;
                    end
                end
            end
            OP_MUL:  start_mul = 1'b1;
            default: ;
        endcase
        sc_flag = {sc_zn ? sc_res[WIDTH-1] : flag_q[2],
                   sc_c,
                   sc_zn ? (sc_res == '0) : flag_q[0]};
    end

    // One iteration step of the running shift or multiply
    logic [WIDTH-1:0]   sh_step, mc_res;
    logic               sh_cout, mc_c, last;
    logic [2*WIDTH-1:0] acc_step;
    logic [2:0]         mc_flag;

    always_comb begin
        sh_step  = shl_q ? {sh_q[WIDTH-2:0], 1'b0} : {1'b0, sh_q[WIDTH-1:1]};
        sh_cout  = shl_q ? sh_q[WIDTH-1] : sh_q[0];
        acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
        if (state_q == SHIFT) begin
            mc_res = sh_step;
            mc_c   = sh_cout;
        end else begin
            mc_res = acc_step[WIDTH-1:0];
            mc_c   = |acc_step[2*WIDTH-1:WIDTH];
        end
        mc_flag = {mc_res[WIDTH-1], mc_c, mc_res == '0};
        last    = (cnt_q == N_ONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sh_q     <= '0;
            shl_q    <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            out_q    <= '0;
            vld_q    <= 1'b0;
            flag_q   <= 3'b000;
        end else begin
            vld_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (start_shift) begin
                            state_q <= SHIFT;
                            shl_q   <= (alu_op == OP_SHL);
                            sh_q    <= (alu_op == OP_SHL) ? in1_shl1 : in1_shr1;
                            cnt_q   <= n - N_ONE;
                        end else if (start_mul) begin
                            // Bit 0 of the multiplier is consumed at the accept edge
                            state_q  <= MUL;
                            acc_q    <= in2[0] ? {{WIDTH{1'b0}}, in1} : '0;
                            mcand_q  <= {{(WIDTH-1){1'b0}}, in1, 1'b0};
                            mplier_q <= {1'b0, in2[WIDTH-1:1]};
                            cnt_q    <= CNT_MUL;
                        end else if (sc_vld) begin
                            out_q  <= sc_res;
                            flag_q <= sc_flag;
                            vld_q  <= 1'b1;
                        end
                    end
                end
                SHIFT, MUL: begin
                    if (flush) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - N_ONE;
                        if (state_q == SHIFT) begin
                            sh_q <= sh_step;
                        end else begin
                            acc_q    <= acc_step;
                            mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
                            mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
                        end
                        if (last) begin
                            state_q <= IDLE;
                            out_q   <= mc_res;
                            flag_q  <= mc_flag;
                            vld_q   <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = (state_q != IDLE);
    assign out_valid = vld_q;
    assign out       = out_q;
    assign flag      = flag_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed scenarios plus a random sweep, checked by a queue-based scoreboard.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [3:0]  alu_op;
    logic [15:0] in1, in2;
    logic        flush;
    logic        busy, out_valid;
    logic [15:0] dut_out;
    logic [2:0]  flag;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [15:0] res;
        logic [2:0]  fl;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] model_out  = 16'h0;
    logic [2:0]  model_flag = 3'b000;

    alu_exec_unit #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .alu_op    (alu_op),
        .in1       (in1),
        .in2       (in2),
        .flush     (flush),
        .busy      (busy),
        .out_valid (out_valid),
        .out       (dut_out),
        .flag      (flag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL global_timeout sim time exceeded");
        $fatal(1, "timeout");
    end

    // Reference behaviour: plain operators, not the iterative datapath
    task automatic model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         output bit has, output logic [15:0] r, output logic [2:0] f, output int lat);
        logic [16:0] s;
        logic [31:0] t;
        logic        c;
        bit          zn;
        int          n;
        has = 1'b1; lat = 1; r = model_out; c = model_flag[1]; zn = 1'b1;
        n = int'(b[3:0]);
        case (op)
            4'h1: begin s = {1'b0, a} + {1'b0, b}; r = s[15:0]; c = s[16]; end
            4'h2: r = ~b;
            4'h3: r = a;
            4'h4: r = b;
            4'h5: begin r = a - b; c = (a < b); end
            4'h6: r = a & b;
            4'h7: r = a | b;
            4'h8: begin s = {1'b0, a} + 17'd1; r = s[15:0]; c = s[16]; end
            4'h9: begin r = a - 16'd1; c = (a == 16'd0); end
            4'hA: begin c = 1'b1; zn = 1'b0; end
            4'hB: begin c = 1'b0; zn = 1'b0; end
            4'hC: begin
                t = {16'h0, a} << n; r = t[15:0];
                if (n != 0) c = t[16];
                lat = (n >= 2) ? n : 1;
            end
            4'hD: begin
                r = a >> n;
                if (n != 0) c = a[n-1];
                lat = (n >= 2) ? n : 1;
            end
            4'hE: begin t = {16'h0, a} * {16'h0, b}; r = t[15:0]; c = |t[31:16]; lat = 16; end
            default: has = 1'b0;
        endcase
        f = {zn ? r[15] : model_flag[2], c, zn ? (r == 16'h0) : model_flag[0]};
    endtask

    // Drive one op at a negedge once the unit is idle; optionally record its expected result
    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input bit push);
        bit          has;
        logic [15:0] r;
        logic [2:0]  f;
        int          lat;
        int          k = 0;
        exp_t        e;
        while (busy === 1'b1 && k < 100) begin @(negedge clk); k++; end
        if (busy !== 1'b0) begin
            checks++; failures++;
            $display("FAIL issue_wait busy=%b required 0", busy);
        end
        in_valid = 1'b1; alu_op = op; in1 = a; in2 = b;
        if (push) begin
            model(op, a, b, has, r, f, lat);
            if (has) begin
                e.res = r; e.fl = f; e.cyc = cyc + lat;
                sb.push_back(e);
                model_out = r; model_flag = f;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 100) begin @(negedge clk); k++; end
        if (sb.size() != 0) begin
            checks++; failures++;
            $display("FAIL drain_timeout pending=%0d required 0", sb.size());
        end
    endtask

    // Scoreboard: every out_valid pulse must match the oldest expectation, value and cycle
    always @(negedge clk) begin
        exp_t e;
        if (out_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected out_valid out=%h flag=%b none expected", dut_out, flag);
            end else begin
                e = sb.pop_front();
                if (dut_out !== e.res) begin
                    failures++;
                    $display("FAIL sb_out got=%h required=%h", dut_out, e.res);
                end
                checks++;
                if (flag !== e.fl) begin
                    failures++;
                    $display("FAIL sb_flag got=%b required=%b", flag, e.fl);
                end
                checks++;
                if (cyc !== e.cyc) begin
                    failures++;
                    $display("FAIL sb_latency cycle=%0d required=%0d", cyc, e.cyc);
                end
            end
        end
    end

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (dut_out !== 16'h0) begin failures++; $display("FAIL reset_out got=%h required=0000", dut_out); end
        checks++; if (flag !== 3'b000) begin failures++; $display("FAIL reset_flag got=%b required=000", flag); end
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_ctrl busy=%b out_valid=%b required 0 0", busy, out_valid);
        end
        rst = 1'b0;
        issue(4'h1, 16'h0003, 16'h0004, 1'b1);
        drain();
        issue(4'hE, 16'h1234, 16'h0056, 1'b0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_mul_busy got=%b required=0", busy); end
        checks++; if (dut_out !== 16'h0) begin failures++; $display("FAIL rst_mid_mul_out got=%h required=0000", dut_out); end
        checks++; if (flag !== 3'b000) begin failures++; $display("FAIL rst_mid_mul_flag got=%b required=000", flag); end
        @(negedge clk);
        rst = 1'b0;
        model_out = 16'h0; model_flag = 3'b000;
        repeat (20) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_after_busy got=%b required=0", busy); end
    endtask

    task automatic test_add_sub_not();
        issue(4'h1, 16'hFFFF, 16'h0001, 1'b1);
        checks++; if (out_valid !== 1'b1 || dut_out !== 16'h0000 || flag !== 3'b011) begin
            failures++; $display("FAIL add_wrap vld=%b out=%h flag=%b required 1 0000 011", out_valid, dut_out, flag);
        end
        issue(4'h5, 16'h0003, 16'h0005, 1'b1);
        checks++; if (dut_out !== 16'hFFFE || flag !== 3'b110) begin
            failures++; $display("FAIL sub_borrow out=%h flag=%b required FFFE 110", dut_out, flag);
        end
        issue(4'h2, 16'h0000, 16'h00FF, 1'b1);
        checks++; if (dut_out !== 16'hFF00 || flag !== 3'b110) begin
            failures++; $display("FAIL not_op out=%h flag=%b required FF00 110", dut_out, flag);
        end
        drain();
    endtask

    task automatic test_shift();
        issue(4'hC, 16'h8001, 16'h0004, 1'b1);
        for (int i = 0; i < 3; i++) begin
            checks++; if (busy !== 1'b1) begin failures++; $display("FAIL shl4_busy cycle%0d got=%b required=1", i, busy); end
            @(negedge clk);
        end
        checks++; if (busy !== 1'b0 || out_valid !== 1'b1 || dut_out !== 16'h0010 || flag !== 3'b000) begin
            failures++; $display("FAIL shl4_done busy=%b vld=%b out=%h flag=%b required 0 1 0010 000", busy, out_valid, dut_out, flag);
        end
        issue(4'hC, 16'h8001, 16'h0001, 1'b1);
        checks++; if (out_valid !== 1'b1 || dut_out !== 16'h0002 || flag !== 3'b010) begin
            failures++; $display("FAIL shl1 vld=%b out=%h flag=%b required 1 0002 010", out_valid, dut_out, flag);
        end
        issue(4'hD, 16'h8001, 16'h0000, 1'b1);
        checks++; if (dut_out !== 16'h8001 || flag !== 3'b110) begin
            failures++; $display("FAIL shr0 out=%h flag=%b required 8001 110", dut_out, flag);
        end
        issue(4'hD, 16'h00F0, 16'h0005, 1'b1);
        issue(4'hC, 16'hFFFF, 16'h000F, 1'b1);
        drain();
        checks++; if (dut_out !== 16'h8000 || flag !== 3'b110) begin
            failures++; $display("FAIL shl15 out=%h flag=%b required 8000 110", dut_out, flag);
        end
    endtask

    task automatic test_mul();
        int k;
        issue(4'hE, 16'h0100, 16'h0100, 1'b1);
        k = 1;
        while (out_valid !== 1'b1 && k < 40) begin @(negedge clk); k++; end
        checks++; if (k != 16) begin failures++; $display("FAIL mul_latency got=%0d required=16", k); end
        checks++; if (dut_out !== 16'h0000 || flag !== 3'b011) begin
            failures++; $display("FAIL mul_ovf out=%h flag=%b required 0000 011", dut_out, flag);
        end
        issue(4'hE, 16'h0007, 16'h0006, 1'b1);
        drain();
        checks++; if (dut_out !== 16'h002A || flag !== 3'b000) begin
            failures++; $display("FAIL mul_7x6 out=%h flag=%b required 002A 000", dut_out, flag);
        end
        issue(4'hE, 16'hFFFF, 16'hFFFF, 1'b1);
        issue(4'hE, 16'h0000, 16'hBEEF, 1'b1);
        drain();
    endtask

    task automatic test_flush();
        logic [15:0] prev_out;
        logic [2:0]  prev_flag;
        prev_out = model_out; prev_flag = model_flag;
        issue(4'hE, 16'h1234, 16'h5678, 1'b0);
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_busy got=%b required=0", busy); end
        checks++; if (dut_out !== prev_out || flag !== prev_flag) begin
            failures++; $display("FAIL flush_hold out=%h flag=%b required %h %b", dut_out, flag, prev_out, prev_flag);
        end
        repeat (20) @(negedge clk);
        in_valid = 1'b1; alu_op = 4'h1; in1 = 16'h0005; in2 = 16'h0005; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        checks++; if (out_valid !== 1'b0 || dut_out !== prev_out) begin
            failures++; $display("FAIL idle_flush vld=%b out=%h required 0 %h", out_valid, dut_out, prev_out);
        end
        issue(4'h1, 16'h0001, 16'h0001, 1'b1);
        checks++; if (dut_out !== 16'h0002 || flag !== 3'b000) begin
            failures++; $display("FAIL post_flush_add out=%h flag=%b required 0002 000", dut_out, flag);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        issue(4'h1, 16'h0000, 16'h0000, 1'b1);
        issue(4'hA, 16'h1111, 16'h2222, 1'b1);
        checks++; if (out_valid !== 1'b1 || flag !== 3'b011 || dut_out !== 16'h0000) begin
            failures++; $display("FAIL setc vld=%b flag=%b out=%h required 1 011 0000", out_valid, flag, dut_out);
        end
        issue(4'hB, 16'h3333, 16'h4444, 1'b1);
        checks++; if (out_valid !== 1'b1 || flag !== 3'b001 || dut_out !== 16'h0000) begin
            failures++; $display("FAIL clrc vld=%b flag=%b out=%h required 1 001 0000", out_valid, flag, dut_out);
        end
        issue(4'h8, 16'hFFFF, 16'h0000, 1'b1);
        issue(4'h9, 16'h0000, 16'h0000, 1'b1);
        issue(4'h0, 16'h1234, 16'h1234, 1'b1);
        issue(4'hF, 16'h1234, 16'h1234, 1'b1);
        drain();
        checks++; if (dut_out !== 16'hFFFF || flag !== 3'b110) begin
            failures++; $display("FAIL dec_zero out=%h flag=%b required FFFF 110", dut_out, flag);
        end
    endtask

    task automatic test_busy_ignore();
        issue(4'hC, 16'h00F1, 16'h0008, 1'b1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; alu_op = 4'h1; in1 = 16'(i); in2 = 16'h0100;
            @(negedge clk);
        end
        in_valid = 1'b0;
        drain();
        checks++; if (dut_out !== 16'hF100 || busy !== 1'b0) begin
            failures++; $display("FAIL busy_ignore out=%h busy=%b required F100 0", dut_out, busy);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            issue(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), 1'b1);
        end
        drain();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; alu_op = 4'h0; in1 = 16'h0; in2 = 16'h0; flush = 1'b0;
        test_reset();
        test_add_sub_not();
        test_shift();
        test_mul();
        test_flush();
        test_back_to_back();
        test_busy_ignore();
        test_random();
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
